// File: rtl/output_buffer.sv
// Two-register skid buffer. The downstream side sees a registered payload/valid,
// and the upstream side sees a registered ready.
module output_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DATA_WIDTH-1:0] skid_reg;
  logic                  out_valid_reg;
  logic                  in_ready_reg;
  logic [1:0]            count_reg;
  logic                  rst_done_reg;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  load_out;
  logic                  load_skid;
  logic                  out_from_skid;

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = out_valid_reg & out_ready;

  always_comb begin
    state_next    = state_reg;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          load_out   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b11: load_out = 1'b1;
          2'b10: begin
            load_skid  = 1'b1;
            state_next = FULL;
          end
          2'b01: state_next = EMPTY;
          default: state_next = BUSY;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_next    = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // rst_done_reg delays in_ready by one extra cycle after reset release.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      count_reg     <= 2'd0;
      rst_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next != EMPTY);
      in_ready_reg  <= rst_done_reg && (state_next != FULL);
      count_reg     <= (state_next == FULL) ? 2'd2 :
                       (state_next == BUSY) ? 2'd1 : 2'd0;
      rst_done_reg  <= 1'b1;
    end
  end

  // Payload registers carry no reset; validity is tracked by the FSM alone.
  always_ff @(posedge aclk) begin
    if (load_out) begin
      out_data_reg <= out_from_skid ? skid_reg : in_data;
    end
    if (load_skid) begin
      skid_reg <= in_data;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 aclk  input  1  clock; all state SHALL change on its rising edge only.
REQ-003 aresetn  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  DATA_WIDTH  upstream payload.
REQ-005 in_valid  input  1  upstream valid.
REQ-006 in_ready  output  1  upstream ready; SHALL be driven directly from a flip-flop with no combinational path from any input.
REQ-007 out_data  output  DATA_WIDTH  downstream payload; SHALL be driven directly from a register.
REQ-008 out_valid  output  1  downstream valid; SHALL be driven directly from a flip-flop.
REQ-009 out_ready  input  1  downstream ready.
REQ-010 count  output  2  occupancy (0, 1 or 2 words held); SHALL be driven from registered state.

Function
REQ-011 A transfer SHALL occur on an interface in a cycle where valid and ready are both 1 at the rising edge of aclk.
REQ-012 Storage SHALL be two DATA_WIDTH registers: an output register (out_data) and a skid register.
REQ-013 The state machine SHALL have three states: EMPTY (count 0), BUSY (count 1, out_valid 1), FULL (count 2, out_valid 1, in_ready 0).
REQ-014 EMPTY with an input transfer: load in_data into the output register and go to BUSY; otherwise stay in EMPTY.
REQ-015 BUSY with input and output transfers in the same cycle: load in_data into the output register and stay in BUSY.
REQ-016 BUSY with an input transfer only: load in_data into the skid register and go to FULL.
REQ-017 BUSY with an output transfer only: go to EMPTY.
REQ-018 BUSY with no transfer: hold all registers.
REQ-019 FULL with an output transfer: copy the skid register into the output register and go to BUSY; otherwise hold.
REQ-020 in_ready SHALL be 1 in the cycle after any edge that leaves the state EMPTY or BUSY, and 0 in the cycle after any edge that leaves it FULL.
REQ-021 Latency from an input transfer to out_valid SHALL be 1 cycle when entering an empty buffer.
REQ-022 With out_ready held at 1, sustained throughput SHALL be one word per cycle with no bubbles.
REQ-023 Words SHALL leave in arrival order; none SHALL be dropped or duplicated.
REQ-024 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 in_data SHALL be ignored when in_ready=0, regardless of in_valid.

Reset
REQ-026 While aresetn=0: state EMPTY, out_valid 0, in_ready 0, count 0.
REQ-027 In the first cycle after aresetn returns to 1, in_ready SHALL still be 0; it SHALL become 1 one cycle later.
REQ-028 Reset asserted mid-operation SHALL discard all held words; no transfer SHALL be reported after the reset edge.
REQ-029 The data registers SHALL NOT be reset.

Structure
REQ-030 State encoding localparams SHALL be local to the module; no shared package is needed.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Reset release with in_valid=1 and in_data=0xA5A5A5A5: no input transfer occurs; in_ready rises 2 cycles after release, then 0xA5A5A5A5 appears on out_data 1 cycle after the accepting edge.
REQ-033 Streaming 0..99 with out_ready=1: 100 words out in order, no gaps, count never exceeds 1.
REQ-034 out_ready=0 and 3 words 0x11, 0x22, 0x33 offered: 0x11 and 0x22 are accepted, in_ready goes to 0 and count=2; after out_ready=1, the output order is 0x11, 0x22, 0x33.
REQ-035 Random in_valid and out_ready (50% each, 10k words, incrementing data): scoreboard matches exactly, and out_data is stable whenever out_valid=1 and out_ready=0.
REQ-036 aresetn pulsed low for 1 cycle while count=2: out_valid=0 and count=0 immediately after, and old words never appear on the output.
REQ-037 In BUSY with a simultaneous input and output transfer: count stays 1 and the new word appears on out_data the next cycle.
